// File: rtl/vga_fb_rect_fill.sv
// Avalon-MM write master filling single-colour rectangles into the frame buffer.
// Define VGA_FB_RECT_CLIP_EN to clamp/drop rectangles against H_RES x V_RES.
module vga_fb_rect_fill #(
  parameter int AVN_AW   = 18,
  parameter int AVN_DW   = 16,
  parameter int RGB_SIZE = 12,
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [X_W-1:0]      cmd_x1,
  input  logic [Y_W-1:0]      cmd_y1,
  input  logic [RGB_SIZE-1:0] cmd_rgb,
  output logic                busy,
  output logic                done,
  output logic                fb_avn_read,
  output logic                fb_avn_write,
  output logic [AVN_AW-1:0]   fb_avn_address,
  output logic [AVN_DW-1:0]   fb_avn_writedata,
  input  logic                fb_avn_waitrequest
);

  localparam int AW1 = AVN_AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [X_W-1:0]      xmin, xmax, x;
  logic [Y_W-1:0]      ymin, ymax, y;
  logic [RGB_SIZE-1:0] rgb;
  logic [AW1-1:0]      row_base;
  logic [AW1-1:0]      rb_setup;

  logic [X_W-1:0] nx_lo, nx_hi;
  logic [Y_W-1:0] ny_lo, ny_hi;
  logic           drop;
  logic           beat, last;

  always_comb begin
    nx_lo = (cmd_x0 > cmd_x1) ? cmd_x1 : cmd_x0;
    nx_hi = (cmd_x0 > cmd_x1) ? cmd_x0 : cmd_x1;
    ny_lo = (cmd_y0 > cmd_y1) ? cmd_y1 : cmd_y0;
    ny_hi = (cmd_y0 > cmd_y1) ? cmd_y0 : cmd_y1;
    drop  = 1'b0;
`ifdef VGA_FB_RECT_CLIP_EN
    drop = (int'(nx_lo) >= H_RES) || (int'(ny_lo) >= V_RES);
    if (int'(nx_hi) > H_RES - 1) nx_hi = X_W'(H_RES - 1);
    if (int'(ny_hi) > V_RES - 1) ny_hi = Y_W'(V_RES - 1);
`endif
  end

  assign beat     = fb_avn_write && !fb_avn_waitrequest;
  assign last     = (x == xmax) && (y == ymax);
  assign rb_setup = AW1'(ymin) * AW1'(H_RES);

  assign busy        = (state != IDLE);
  assign cmd_ready   = !busy;
  assign done        = (state == DONE);
  assign fb_avn_read = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (cmd_valid) state_n = drop ? DONE : SETUP;
      SETUP: state_n = WRITE;
      WRITE: if (beat && last) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      xmin             <= '0;
      xmax             <= '0;
      ymin             <= '0;
      ymax             <= '0;
      x                <= '0;
      y                <= '0;
      rgb              <= '0;
      row_base         <= '0;
      fb_avn_write     <= 1'b0;
      fb_avn_address   <= '0;
      fb_avn_writedata <= '0;
    end else begin
      unique case (state)
        IDLE: if (cmd_valid) begin
          xmin <= nx_lo;
          xmax <= nx_hi;
          ymin <= ny_lo;
          ymax <= ny_hi;
          rgb  <= cmd_rgb;
        end
        SETUP: begin
          row_base         <= rb_setup;
          fb_avn_address   <= AVN_AW'(rb_setup + AW1'(xmin));
          x                <= xmin;
          y                <= ymin;
          fb_avn_writedata <= AVN_DW'(rgb);
          fb_avn_write     <= 1'b1;
        end
        WRITE: if (beat) begin
          if (x != xmax) begin
            x              <= x + X_W'(1);
            fb_avn_address <= fb_avn_address + AVN_AW'(1);
          end else if (y != ymax) begin
            x              <= xmin;
            y              <= y + Y_W'(1);
            row_base       <= row_base + AW1'(H_RES);
            fb_avn_address <= AVN_AW'(row_base + AW1'(H_RES) + AW1'(xmin));
          end else begin
            fb_avn_write   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
